cordic_sincos_pipe: RTL and testbench

Parametrised, fully pipelined CORDIC rotator producing cosine and sine of a binary-angle input, one sample per enabled clock. It is the next generation of the fixed 24-bit, 16-stage cosine core and sits as an Avalon-facing compute unit behind the Nios II custom-instruction and DMA wrappers. It adds configurable width and depth, a sine output, arithmetic-correct shifts, output rounding and saturation, a valid/tag sideband, flush, and an optional full-circle quadrant correction.

---
 rtl/cordic_sincos_pipe.sv | 181 ++++++++++++++++++
 tb/tb_cordic_sincos_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sincos_pipe.sv
// Pipelined CORDIC rotator: cosine and sine of a binary angle, one sample per enabled clock.
// Latency STAGES+2 enabled cycles; clk_en low stalls the whole pipe, flush drops all in-flight samples.
// No backpressure: consumer must take every out_valid. CORDIC_FULL_RANGE_EN adds quadrant correction.
module cordic_sincos_pipe #(
    parameter int WIDTH  = 24,
    parameter int STAGES = 16,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_angle,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_cos,
    output logic [WIDTH-1:0] out_sin,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int XW = WIDTH + 2;

    // round(atan(2^-i) * 2^32 / 2pi)
    function automatic logic [31:0] atan_tab(input int i);
        case (i)
            0:  return 32'h2000_0000;  1:  return 32'h12E4_051E;
            2:  return 32'h09FB_385B;  3:  return 32'h0511_11D4;
            4:  return 32'h028B_0D43;  5:  return 32'h0145_D7E1;
            6:  return 32'h00A2_F61E;  7:  return 32'h0051_7C55;
            8:  return 32'h0028_BE53;  9:  return 32'h0014_5F2F;
            10: return 32'h000A_2F98;  11: return 32'h0005_17CC;
            12: return 32'h0002_8BE6;  13: return 32'h0001_45F3;
            14: return 32'h0000_A2FA;  15: return 32'h0000_517D;
            16: return 32'h0000_28BE;  17: return 32'h0000_145F;
            18: return 32'h0000_0A30;  19: return 32'h0000_0518;
            20: return 32'h0000_028C;  21: return 32'h0000_0146;
            22: return 32'h0000_00A3;  23: return 32'h0000_0051;
            24: return 32'h0000_0029;  25: return 32'h0000_0014;
            26: return 32'h0000_000A;  27: return 32'h0000_0005;
            28: return 32'h0000_0003;  29: return 32'h0000_0001;
            30: return 32'h0000_0001;
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Round a 32-bit fraction of a full circle down to WIDTH bits.
    function automatic logic [WIDTH-1:0] scale_ang(input logic [31:0] v);
        logic [32:0] t;
        t = {1'b0, v} + ((33'd1 << (32 - WIDTH)) >> 1);
        return WIDTH'(t >> (32 - WIDTH));
    endfunction

    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH+1:0] v);
        if (v[WIDTH+1:WIDTH-1] == 3'b000 || v[WIDTH+1:WIDTH-1] == 3'b111)
            return v[WIDTH-1:0];
        return v[WIDTH+1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    // Inverse CORDIC gain 0.607252935 with WIDTH fraction bits (2 guard bits below the output LSB).
    localparam logic signed [XW-1:0] X0 = {2'b00, scale_ang(32'h9B74_EDA8)};

    logic [STAGES:0]         vld_q;
    logic [TAG_W-1:0]        tag_q [0:STAGES];
    logic signed [XW-1:0]    x_q   [0:STAGES];
    logic signed [XW-1:0]    y_q   [0:STAGES];
    logic [WIDTH-1:0]        z_q   [0:STAGES-1];
    logic signed [XW-1:0]    x_d   [1:STAGES];
    logic signed [XW-1:0]    y_d   [1:STAGES];
    logic [WIDTH-1:0]        z_d   [1:STAGES-1];
    logic [WIDTH-1:0]        z0_d;

    logic                    ovld_q;
    logic [WIDTH-1:0]        cos_q, sin_q;
    logic [TAG_W-1:0]        otag_q;
    logic [WIDTH-1:0]        cos_d, sin_d;

`ifdef CORDIC_FULL_RANGE_EN
    logic [STAGES:0] neg_q;
    logic            flip;

    // Quadrants 1 and 2 are folded by 180 degrees; the result is negated at the output.
    assign flip = in_angle[WIDTH-1] ^ in_angle[WIDTH-2];
    assign z0_d = {in_angle[WIDTH-1] ^ flip, in_angle[WIDTH-2:0]};
`else
    assign z0_d = in_angle;
`endif

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        localparam logic [WIDTH-1:0] ANG = scale_ang(atan_tab(i));
        logic signed [XW-1:0] xsh, ysh;
        logic                 zneg;

        assign xsh  = x_q[i] >>> i;
        assign ysh  = y_q[i] >>> i;
        assign zneg = z_q[i][WIDTH-1];
        assign x_d[i+1] = zneg ? x_q[i] + ysh : x_q[i] - ysh;
        assign y_d[i+1] = zneg ? y_q[i] - xsh : y_q[i] + xsh;
        if (i < STAGES - 1) begin : g_z
            assign z_d[i+1] = zneg ? z_q[i] + ANG : z_q[i] - ANG;
        end
    end

    logic signed [XW:0]      xr, yr;
    logic signed [WIDTH:0]   xc, yc;
    logic signed [WIDTH+1:0] xe, ye;

    // Drop the 2 guard bits with round-half-up; WIDTH+1 bits keeps the overflow for saturation.
    assign xr = {x_q[STAGES][XW-1], x_q[STAGES]} + (XW+1)'(2);
    assign yr = {y_q[STAGES][XW-1], y_q[STAGES]} + (XW+1)'(2);
    assign xc = (WIDTH+1)'(xr >>> 2);
    assign yc = (WIDTH+1)'(yr >>> 2);

`ifdef CORDIC_FULL_RANGE_EN
    assign xe = neg_q[STAGES] ? -{xc[WIDTH], xc} : {xc[WIDTH], xc};
    assign ye = neg_q[STAGES] ? -{yc[WIDTH], yc} : {yc[WIDTH], yc};
`else
    assign xe = {xc[WIDTH], xc};
    assign ye = {yc[WIDTH], yc};
`endif

    assign cos_d = sat(xe);
    assign sin_d = sat(ye);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= '0;
            ovld_q <= 1'b0;
            cos_q  <= '0;
            sin_q  <= '0;
            otag_q <= '0;
            for (int k = 0; k <= STAGES; k++) begin
                tag_q[k] <= '0;
                x_q[k]   <= '0;
                y_q[k]   <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                z_q[k] <= '0;
            end
`ifdef CORDIC_FULL_RANGE_EN
            neg_q <= '0;
`endif
        end else begin
            if (clk_en) begin
                x_q[0]   <= X0;
                y_q[0]   <= '0;
                z_q[0]   <= z0_d;
                tag_q[0] <= in_tag;
                for (int k = 1; k <= STAGES; k++) begin
                    x_q[k]   <= x_d[k];
                    y_q[k]   <= y_d[k];
                    tag_q[k] <= tag_q[k-1];
                end
                for (int k = 1; k < STAGES; k++) begin
                    z_q[k] <= z_d[k];
                end
                cos_q  <= cos_d;
                sin_q  <= sin_d;
                otag_q <= tag_q[STAGES];
`ifdef CORDIC_FULL_RANGE_EN
                neg_q <= {neg_q[STAGES-1:0], flip};
`endif
            end
            if (flush) begin
                vld_q  <= '0;
                ovld_q <= 1'b0;
            end else if (clk_en) begin
                vld_q  <= {vld_q[STAGES-1:0], in_valid};
                ovld_q <= vld_q[STAGES];
            end
        end
    end

    assign out_valid = ovld_q;
    assign out_cos   = cos_q;
    assign out_sin   = sin_q;
    assign out_tag   = otag_q;
    assign busy      = (|vld_q) | ovld_q;

endmodule

// File: tb/tb_cordic_sincos_pipe.sv
// Scoreboard bench for cordic_sincos_pipe at WIDTH=24, STAGES=16; directed angles with hand-computed results.
module tb_cordic_sincos_pipe;

    localparam int W   = 24;
    localparam int S   = 16;
    localparam int TW  = 4;
    localparam int LAT = S + 2;
    localparam int TOL = 256;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clk_en = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_angle = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic [W-1:0]  out_cos, out_sin;
    logic [TW-1:0] out_tag;
    logic          busy;

    cordic_sincos_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(TW)) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .flush(flush),
        .in_valid(in_valid), .in_angle(in_angle), .in_tag(in_tag),
        .out_valid(out_valid), .out_cos(out_cos), .out_sin(out_sin),
        .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  c;
        logic [W-1:0]  s;
        logic [TW-1:0] tag;
        int            e0;
        int            w0;
        int            wlat;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   ecnt = 0;
    int   wcnt = 0;
    logic en_last = 1'b0;

    always @(posedge clk) begin
        wcnt    <= wcnt + 1;
        en_last <= clk_en && reset_n;
        if (clk_en && reset_n) ecnt <= ecnt + 1;
    end

    task automatic chk_near(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        int d;
        checks++;
        d = int'($signed(act)) - int'($signed(req));
        if (d < 0) d = -d;
        if (d > TOL) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (+/-%0d)", nm, act, req, TOL);
        end
    endtask

    task automatic chk_eq(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    // Monitor: every newly loaded output is matched against the oldest pending expectation.
    always @(negedge clk) begin
        if (reset_n && en_last && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: out_valid with tag=%0d, required no output", out_tag);
            end else begin
                cur = exp_q.pop_front();
                chk_near("cos", out_cos, cur.c);
                chk_near("sin", out_sin, cur.s);
                chk_eq("tag", int'(out_tag), int'(cur.tag));
                chk_eq("latency_enabled", ecnt - cur.e0, LAT);
                chk_eq("latency_wall", wcnt - cur.w0, cur.wlat);
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [TW-1:0] t,
                        input logic [W-1:0] c, input logic [W-1:0] s, input int wl);
        exp_t e;
        in_valid = 1'b1;
        in_angle = a;
        in_tag   = t;
        e.c = c; e.s = s; e.tag = t; e.e0 = ecnt; e.w0 = wcnt; e.wlat = wl;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drive_only(input logic [W-1:0] a, input logic [TW-1:0] t);
        in_valid = 1'b1;
        in_angle = a;
        in_tag   = t;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 80) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: pending=%0d required=0", nm, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_eq("reset_out_valid", int'(out_valid), 0);
        chk_eq("reset_busy", int'(busy), 0);
        chk_eq("reset_cos", int'(out_cos), 0);
        chk_eq("reset_sin", int'(out_sin), 0);
        chk_eq("reset_tag", int'(out_tag), 0);
        reset_n = 1'b1;
        @(negedge clk);

        send(24'h000000, 4'h3, 24'h400000, 24'h000000, LAT);
        drain("angle0");

        send(24'h200000, 4'h1, 24'h2D413D, 24'h2D413D, LAT);
        send(24'h400000, 4'h2, 24'h000000, 24'h400000, LAT);
        send(24'hE00000, 4'h4, 24'h2D413D, 24'hD2BEC3, LAT);
        send(24'hC00000, 4'h5, 24'h000000, 24'hC00000, LAT);
        send(24'h155555, 4'h6, 24'h376CF8, 24'h200000, LAT);
        send(24'hD55555, 4'h7, 24'h200000, 24'hC89308, LAT);
`ifdef CORDIC_FULL_RANGE_EN
        send(24'h800000, 4'h8, 24'hC00000, 24'h000000, LAT);
        send(24'hA00000, 4'h9, 24'hD2BEC3, 24'hD2BEC3, LAT);
        send(24'h600000, 4'hA, 24'hD2BEC3, 24'h2D413D, LAT);
`endif
        drain("angles");

        // Five back-to-back samples, a 3-cycle stall mid-pipe, then a 2-cycle stall with tag 1 on the output.
        send(24'h000000, 4'h0, 24'h400000, 24'h000000, LAT + 3);
        send(24'h200000, 4'h1, 24'h2D413D, 24'h2D413D, LAT + 3);
        send(24'h400000, 4'h2, 24'h000000, 24'h400000, LAT + 5);
        send(24'hE00000, 4'h3, 24'h2D413D, 24'hD2BEC3, LAT + 5);
        send(24'h155555, 4'h4, 24'h376CF8, 24'h200000, LAT + 5);
        repeat (3) @(negedge clk);
        clk_en = 1'b0;
        repeat (3) @(negedge clk);
        clk_en = 1'b1;
        n = 0;
        while (!(out_valid && out_tag == 4'h1) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk_eq("stall_wait_tag1", int'(out_valid && out_tag == 4'h1), 1);
        clk_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk_eq("stall_hold_valid", int'(out_valid), 1);
            chk_eq("stall_hold_tag", int'(out_tag), 1);
            chk_near("stall_hold_cos", out_cos, 24'h2D413D);
            chk_near("stall_hold_sin", out_sin, 24'h2D413D);
        end
        clk_en = 1'b1;
        drain("stall");

        // Flush while two samples are about 10 stages in; the flush-cycle input is dropped.
        drive_only(24'h200000, 4'h5);
        drive_only(24'h400000, 4'h6);
        repeat (8) @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_angle = 24'hE00000;
        in_tag   = 4'h9;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_eq("flush_busy", int'(busy), 0);
        send(24'h155555, 4'h7, 24'h376CF8, 24'h200000, LAT);
        drain("flush");

        // Asynchronous reset with six samples in flight.
        for (int k = 0; k < 6; k++) drive_only(24'h100000, TW'(k + 8));
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete();
        chk_eq("midreset_out_valid", int'(out_valid), 0);
        chk_eq("midreset_busy", int'(busy), 0);
        chk_eq("midreset_cos", int'(out_cos), 0);
        chk_eq("midreset_sin", int'(out_sin), 0);
        chk_eq("midreset_tag", int'(out_tag), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        send(24'hD55555, 4'hB, 24'h200000, 24'hC89308, LAT);
        drain("reset");
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
